// File: rtl/dm_arb_pkg.sv
// ============================================================================
//  Module   : dm_arb_pkg
//  Purpose  : Shared DMType encodings, arbiter FSM state type and the
//             alignment helper used by the data-memory port arbiter.
//  Options  : DM_ARB_ALIGN_CHK_EN (consumer side) enables misalignment checks
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_arb_pkg;

   // Access-size encodings understood by the data memory
   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   // Sequencer states: accept a command, then own the dm port for one cycle
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } arb_state_e;

   // Word accesses need addr[1:0]==0, half accesses need addr[0]==0;
   // byte accesses are always aligned.
   function automatic logic dm_misaligned(input logic [2:0] dm_type,
                                          input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (dm_type)
         DM_WORD:            mis = (addr_lo != 2'b00);
         DM_HALF, DM_HALF_U: mis = addr_lo[0];
         default:            mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Combinational two-way round-robin picker. A lone requester
//             always wins; on contention the requester named by prio wins.
//             Grant is one-hot or zero. The prio register lives in the parent.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
   import dm_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       prio,
   output logic [1:0] grant
);

   // Pick a winner: uncontested requests pass, contention resolved by prio
   always_comb begin
      grant    = 2'b00;
      grant[0] = valid[0] & (~valid[1] | ~prio);
      grant[1] = valid[1] & (~valid[0] |  prio);
   end

endmodule

`default_nettype wire

// File: rtl/dm_port_arbiter.sv
// ============================================================================
//  Module   : dm_port_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one data-memory port
//             between the MEM stage (req0) and a debug/DMA master (req1).
//             One access in flight; dm driven for one cycle per access;
//             registered response returned only to the issuing requester.
//  Options  : DM_ARB_ALIGN_CHK_EN - flag misaligned word/half accesses,
//             suppress their store strobe and return rsp_err=1, rdata=0.
//             Undefined: rsp_err tied 0, all accesses pass through.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_port_arbiter
   import dm_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rstn,

   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic          req0_we,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   input  logic [2:0]    req0_type,

   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic          req1_we,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   input  logic [2:0]    req1_type,

   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_rdata,
   output logic          rsp0_err,

   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_rdata,
   output logic          rsp1_err,

   output logic          dm_DMWr,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_din,
   output logic [2:0]    dm_DMType,
   input  logic [DW-1:0] dm_dout
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   arb_state_e    state_q;
   logic          prio_q;

   // Command register: the access currently owning (or last owning) dm
   logic          cmd_we_q;
   logic [AW-1:0] cmd_addr_q;
   logic [DW-1:0] cmd_wdata_q;
   logic [2:0]    cmd_type_q;
   logic          cmd_owner_q;
   logic          cmd_err_q;

   // Response registers, one set per requester so the idle side stays 0
   logic [1:0]    rsp_valid_q;
   logic [DW-1:0] rsp0_rdata_q;
   logic [DW-1:0] rsp1_rdata_q;

   // ------------------------------------------------------------------------
   // Arbitration and request selection
   // ------------------------------------------------------------------------
   logic [1:0]    grant;
   logic          sel_we_d;
   logic [AW-1:0] sel_addr_d;
   logic [DW-1:0] sel_wdata_d;
   logic [2:0]    sel_type_d;
   logic          sel_err_d;
   logic [DW-1:0] rsp_data_d;

   rr_arb2 u_rr_arb2 (
      .valid ({req1_valid, req0_valid}),
      .prio  (prio_q),
      .grant (grant)
   );

   // Route the granted requester's command fields toward the command register
   always_comb begin
      sel_we_d    = req0_we;
      sel_addr_d  = req0_addr;
      sel_wdata_d = req0_wdata;
      sel_type_d  = req0_type;
      if (grant[1]) begin
         sel_we_d    = req1_we;
         sel_addr_d  = req1_addr;
         sel_wdata_d = req1_wdata;
         sel_type_d  = req1_type;
      end
   end

`ifdef DM_ARB_ALIGN_CHK_EN
   assign sel_err_d = dm_misaligned(sel_type_d, sel_addr_d[1:0]);
`else
   assign sel_err_d = 1'b0;
`endif

   // Stores and rejected accesses return zero data; loads return dm read data
   assign rsp_data_d = (cmd_we_q | cmd_err_q) ? '0 : dm_dout;

   // ------------------------------------------------------------------------
   // Handshake and dm port outputs
   // ------------------------------------------------------------------------
   // Ready is only offered in IDLE, and only to the arbitration winner
   assign req0_ready = (state_q == ST_IDLE) & grant[0];
   assign req1_ready = (state_q == ST_IDLE) & grant[1];

   // Write strobe derives from the async-reset state so it drops with rstn
   assign dm_DMWr   = (state_q == ST_ACCESS) & cmd_we_q & ~cmd_err_q;
   assign dm_addr   = cmd_addr_q;
   assign dm_din    = cmd_wdata_q;
   assign dm_DMType = cmd_type_q;

   assign rsp0_valid = rsp_valid_q[0];
   assign rsp1_valid = rsp_valid_q[1];
   assign rsp0_rdata = rsp0_rdata_q;
   assign rsp1_rdata = rsp1_rdata_q;

`ifdef DM_ARB_ALIGN_CHK_EN
   logic [1:0] rsp_err_q;
   assign rsp0_err = rsp_err_q[0];
   assign rsp1_err = rsp_err_q[1];
`else
   assign rsp0_err = 1'b0;
   assign rsp1_err = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------------
   // IDLE latches a granted command; ACCESS drives dm and captures the reply
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         prio_q       <= 1'b0;
         cmd_we_q     <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         cmd_type_q   <= DM_WORD;
         cmd_owner_q  <= 1'b0;
         cmd_err_q    <= 1'b0;
         rsp_valid_q  <= 2'b00;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
`ifdef DM_ARB_ALIGN_CHK_EN
         rsp_err_q    <= 2'b00;
`endif
      end else begin
         // Responses are single-cycle pulses; data returns to 0 afterwards
         rsp_valid_q  <= 2'b00;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
`ifdef DM_ARB_ALIGN_CHK_EN
         rsp_err_q    <= 2'b00;
`endif
         case (state_q)
            ST_IDLE: begin
               if (|grant) begin
                  cmd_we_q    <= sel_we_d;
                  cmd_addr_q  <= sel_addr_d;
                  cmd_wdata_q <= sel_wdata_d;
                  cmd_type_q  <= sel_type_d;
                  cmd_err_q   <= sel_err_d;
                  cmd_owner_q <= grant[1];
                  // Hand priority to the requester that just lost its turn
                  prio_q      <= ~grant[1];
                  state_q     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               rsp_valid_q[cmd_owner_q] <= 1'b1;
               if (cmd_owner_q) begin
                  rsp1_rdata_q <= rsp_data_d;
               end else begin
                  rsp0_rdata_q <= rsp_data_d;
               end
`ifdef DM_ARB_ALIGN_CHK_EN
               rsp_err_q[cmd_owner_q] <= cmd_err_q;
`endif
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
// ============================================================================
//  Module   : tb_dm_port_arbiter
//  Purpose  : Directed self-checking bench for dm_port_arbiter with a small
//             behavioural byte/half/word data memory on the dm port.
//  Options  : DM_ARB_ALIGN_CHK_EN selects misaligned-access expectations
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dm_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [2:0] T_W  = 3'b000;
   localparam logic [2:0] T_H  = 3'b001;
   localparam logic [2:0] T_HU = 3'b010;
   localparam logic [2:0] T_B  = 3'b011;
   localparam logic [2:0] T_BU = 3'b100;

`ifdef DM_ARB_ALIGN_CHK_EN
   localparam logic MIS_ERR = 1'b1;
   localparam logic MIS_WR  = 1'b0;
`else
   localparam logic MIS_ERR = 1'b0;
   localparam logic MIS_WR  = 1'b1;
`endif

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic          req0_valid = 1'b0, req0_we = 1'b0;
   logic [AW-1:0] req0_addr  = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic [2:0]    req0_type  = T_W;
   logic          req1_valid = 1'b0, req1_we = 1'b0;
   logic [AW-1:0] req1_addr  = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic [2:0]    req1_type  = T_W;
   logic          req0_ready, req1_ready;
   logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [DW-1:0] rsp0_rdata, rsp1_rdata;
   logic          dm_DMWr;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_din;
   logic [2:0]    dm_DMType;
   logic [DW-1:0] dm_dout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dm_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req0_type  (req0_type),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .req1_type  (req1_type),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .rsp0_err   (rsp0_err),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .rsp1_err   (rsp1_err),
      .dm_DMWr    (dm_DMWr),
      .dm_addr    (dm_addr),
      .dm_din     (dm_din),
      .dm_DMType  (dm_DMType),
      .dm_dout    (dm_dout)
   );

   // ---------------------------------------------------------------- memory
   logic [31:0] mem [0:63];
   logic [31:0] rd_word;
   logic [15:0] rd_h;
   logic [7:0]  rd_b;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + 32'(i) * 32'h0101;
   end

   always @(posedge clk) begin
      if (dm_DMWr) begin
         case (dm_DMType)
            T_B, T_BU: mem[dm_addr[7:2]][8*dm_addr[1:0] +: 8]  <= dm_din[7:0];
            T_H, T_HU: mem[dm_addr[7:2]][16*dm_addr[1] +: 16]  <= dm_din[15:0];
            default:   mem[dm_addr[7:2]]                       <= dm_din;
         endcase
      end
   end

   always_comb begin
      rd_word = mem[dm_addr[7:2]];
      rd_b    = rd_word[8*dm_addr[1:0] +: 8];
      rd_h    = rd_word[16*dm_addr[1] +: 16];
      case (dm_DMType)
         T_H:     dm_dout = {{16{rd_h[15]}}, rd_h};
         T_HU:    dm_dout = {16'h0000, rd_h};
         T_B:     dm_dout = {{24{rd_b[7]}}, rd_b};
         T_BU:    dm_dout = {24'h000000, rd_b};
         default: dm_dout = rd_word;
      endcase
   end

   // ---------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int r, input logic v, input logic we,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t);
      if (r == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = wd; req0_type = t;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = wd; req1_type = t;
      end
   endtask

   function automatic logic ready_of(input int r);
      return (r == 0) ? req0_ready : req1_ready;
   endfunction

   // One complete access: handshake, ACCESS cycle, response cycle, quiet cycle
   task automatic xfer(input string tag, input int r, input logic we,
                       input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t,
                       input logic [31:0] exp_rd, input logic exp_err, input logic exp_wr);
      int cnt;
      logic [31:0] own_d, oth_d;
      logic own_v, own_e, oth_v, oth_e;
      drive(r, 1'b1, we, a, wd, t);
      #1;
      cnt = 0;
      while (!ready_of(r) && cnt < 20) begin
         @(negedge clk); #1;
         cnt++;
      end
      if (!ready_of(r)) begin
         check({tag, "_grant_timeout"}, 32'd0, 32'd1);
         drive(r, 1'b0, 1'b0, 32'd0, 32'd0, T_W);
         return;
      end
      @(negedge clk);
      drive(r, 1'b0, 1'b0, 32'd0, 32'd0, T_W);
      check({tag, "_dmwr_access"}, {31'd0, dm_DMWr}, {31'd0, exp_wr});
      check({tag, "_dm_addr"}, dm_addr, a);
      check({tag, "_ready_access"}, {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      own_v = (r == 0) ? rsp0_valid : rsp1_valid;
      own_d = (r == 0) ? rsp0_rdata : rsp1_rdata;
      own_e = (r == 0) ? rsp0_err   : rsp1_err;
      oth_v = (r == 0) ? rsp1_valid : rsp0_valid;
      oth_d = (r == 0) ? rsp1_rdata : rsp0_rdata;
      oth_e = (r == 0) ? rsp1_err   : rsp0_err;
      check({tag, "_rsp_valid"}, {31'd0, own_v}, 32'd1);
      check({tag, "_rsp_rdata"}, own_d, exp_rd);
      check({tag, "_rsp_err"}, {31'd0, own_e}, {31'd0, exp_err});
      check({tag, "_other_rsp"}, {30'd0, oth_v, oth_e}, 32'd0);
      check({tag, "_other_rdata"}, oth_d, 32'd0);
      check({tag, "_dmwr_after"}, {31'd0, dm_DMWr}, 32'd0);
      @(negedge clk);
      check({tag, "_rsp_pulse_end"}, {31'd0, own_v & 1'b0} | {31'd0, (r == 0) ? rsp0_valid : rsp1_valid}, 32'd0);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [7:0] e_r0, e_r1, e_v0, e_v1;
      int cnt;
      e_r0 = 8'b0001_0001;
      e_r1 = 8'b0100_0100;
      e_v0 = 8'b0100_0100;
      e_v1 = 8'b0001_0000;

      // Reset values
      @(negedge clk); @(negedge clk);
      check("rst_ready",  {30'd0, req1_ready, req0_ready}, 32'd0);
      check("rst_rsp",    {28'd0, rsp1_valid, rsp1_err, rsp0_valid, rsp0_err}, 32'd0);
      check("rst_rdata",  rsp0_rdata | rsp1_rdata, 32'd0);
      check("rst_dmwr",   {31'd0, dm_DMWr}, 32'd0);
      check("rst_dm_cmd", dm_addr | dm_din | {29'd0, dm_DMType}, 32'd0);
      rstn = 1'b1;

      // Both requesters valid from reset: grants alternate 0,1,0,1
      drive(0, 1'b1, 1'b0, 32'h10, 32'd0, T_W);
      drive(1, 1'b1, 1'b0, 32'h20, 32'd0, T_W);
      #1;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("rr_ready0_c%0d", k), {31'd0, req0_ready}, {31'd0, e_r0[k]});
         check($sformatf("rr_ready1_c%0d", k), {31'd0, req1_ready}, {31'd0, e_r1[k]});
         check($sformatf("rr_rsp0_c%0d", k),   {31'd0, rsp0_valid}, {31'd0, e_v0[k]});
         check($sformatf("rr_rsp1_c%0d", k),   {31'd0, rsp1_valid}, {31'd0, e_v1[k]});
         check($sformatf("rr_rdata0_c%0d", k), rsp0_rdata, e_v0[k] ? 32'hA500_0404 : 32'd0);
         check($sformatf("rr_rdata1_c%0d", k), rsp1_rdata, e_v1[k] ? 32'hA500_0808 : 32'd0);
         @(negedge clk); #1;
      end
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, T_W);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0, T_W);
      check("rr_rsp1_c8", {31'd0, rsp1_valid}, 32'd1);
      check("rr_rdata1_c8", rsp1_rdata, 32'hA500_0808);
      @(negedge clk);

      // Store then load through req0; byte/half sign handling via both ports
      xfer("sw0",    0, 1'b1, 32'h10, 32'hDEAD_BEEF, T_W,  32'h0,          1'b0, 1'b1);
      xfer("lw0",    0, 1'b0, 32'h10, 32'h0,         T_W,  32'hDEAD_BEEF,  1'b0, 1'b0);
      xfer("sb1",    1, 1'b1, 32'h13, 32'h0000_0080, T_B,  32'h0,          1'b0, 1'b1);
      xfer("lb0",    0, 1'b0, 32'h13, 32'h0,         T_B,  32'hFFFF_FF80,  1'b0, 1'b0);
      xfer("lbu1",   1, 1'b0, 32'h13, 32'h0,         T_BU, 32'h0000_0080,  1'b0, 1'b0);
      xfer("lh0",    0, 1'b0, 32'h12, 32'h0,         T_H,  32'hFFFF_80AD,  1'b0, 1'b0);
      xfer("lhu1",   1, 1'b0, 32'h12, 32'h0,         T_HU, 32'h0000_80AD,  1'b0, 1'b0);

      // Misaligned word store
      xfer("sw_mis", 1, 1'b1, 32'h12, 32'hCAFE_F00D, T_W,  32'h0,          MIS_ERR, MIS_WR);
      xfer("lw_chk", 0, 1'b0, 32'h10, 32'h0,         T_W,
           MIS_WR ? 32'hCAFE_F00D : 32'h80AD_BEEF, 1'b0, 1'b0);

      // Reset during ACCESS of a store (req0 last granted, so prio is 1)
      drive(0, 1'b1, 1'b1, 32'h30, 32'h1234_5678, T_W);
      #1;
      cnt = 0;
      while (!req0_ready && cnt < 20) begin
         @(negedge clk); #1;
         cnt++;
      end
      check("rstmid_grant", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, T_W);
      check("rstmid_dmwr_before", {31'd0, dm_DMWr}, 32'd1);
      #1 rstn = 1'b0;
      #1 check("rstmid_dmwr_drop", {31'd0, dm_DMWr}, 32'd0);
      @(negedge clk);
      check("rstmid_no_rsp_a", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(negedge clk);
      check("rstmid_no_rsp_b", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      check("rstmid_no_rsp_c", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

      // First grant after reset goes to req0; memory word at 0x30 untouched
      drive(0, 1'b1, 1'b0, 32'h30, 32'd0, T_W);
      drive(1, 1'b1, 1'b0, 32'h20, 32'd0, T_W);
      #1;
      check("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, T_W);
      @(negedge clk);
      check("post_rst_rsp0", {31'd0, rsp0_valid}, 32'd1);
      check("post_rst_mem30", rsp0_rdata, 32'hA500_0C0C);
      check("post_rst_ready1", {31'd0, req1_ready}, 32'd1);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0, T_W);
      @(negedge clk);
      check("post_rst_rsp1", {31'd0, rsp1_valid}, 32'd1);
      check("post_rst_rdata1", rsp1_rdata, 32'hA500_0808);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Bound the whole run
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
